// File: rtl/data_ram_if.sv
// data_ram_if: load/store bus between the core's MEM stage and the data RAM.
//   master : core side. Drives the store strobe, store address/data and the load
//            address, and receives the load data.
//   slave  : responder side.
// Signals:
//   ram_wreg  - store strobe; one full word is written per cycle while high
//   ram_waddr - store byte address (bits [1:0] ignored)
//   ram_wdata - store data
//   raddr     - load byte address (bits [1:0] ignored)
//   rdata     - load data, combinational from raddr
interface data_ram_if;
  logic        ram_wreg;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [31:0] raddr;
  logic [31:0] rdata;

  modport master (output ram_wreg, ram_waddr, ram_wdata, raddr, input rdata);
  modport slave  (input ram_wreg, ram_waddr, ram_wdata, raddr, output rdata);
endinterface

// File: rtl/data_ram_responder.sv
// data_ram_responder: word-organised data RAM serving the core's load/store port.
//   - Loads are combinational and have zero latency; the core has no stall path.
//   - Stores are registered.
//   - A store to the word being loaded in the same cycle is forwarded to rdata.
//   - After reset, a sweep clears every word (DEPTH cycles). During the sweep,
//     busy_o is high, loads return 0 and stores are dropped.
// Optional macro DATA_RAM_MMIO_EN adds a 16-byte MMIO window at MMIO_BASE:
//   word 0 = CYCLE (read-only), 1 = GPIO, 2 = TOHOST/halt, 3 = reserved.
//   Without the macro the window is unmapped and gpio_o/halt_o/tohost_o are 0.
// Ports:
//   clk      - clock; all state updates on posedge
//   rst      - synchronous reset, active high
//   bus      - data_ram_if.slave (store strobe/address/data, load address/data)
//   busy_o   - high while the clear sweep runs (and while rst is held)
//   gpio_o   - GPIO register value
//   halt_o   - sticky test-done flag; set by a nonzero TOHOST write
//   tohost_o - last value written to TOHOST
module data_ram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 10,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_if.slave        bus,
  output logic             busy_o,
  output logic [31:0]      gpio_o,
  output logic             halt_o,
  output logic [31:0]      tohost_o
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_ptr;
  logic [31:0]   r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          w_wr_ram_hit, w_rd_ram_hit;
  logic [AW-1:0] w_wr_idx, w_rd_idx;
  logic          w_ready;
  logic          w_wr_en;
  logic          w_bypass;

  assign w_wr_ram_hit = (bus.ram_waddr[31:AW+2] == '0);
  assign w_rd_ram_hit = (bus.raddr[31:AW+2] == '0);
  assign w_wr_idx     = bus.ram_waddr[AW+1:2];
  assign w_rd_idx     = bus.raddr[AW+1:2];
  assign w_ready      = (r_state == S_READY);
  // Core stores are accepted only once the sweep has finished.
  assign w_wr_en      = w_ready && !rst && bus.ram_wreg;
  assign w_bypass     = bus.ram_wreg && w_wr_ram_hit && (w_wr_idx == w_rd_idx);

  // Sub-word address bits are the MEM stage's business; the parameter base is
  // only partially used depending on the build.
  logic w_unused;
  assign w_unused = ^{bus.raddr[1:0], bus.ram_waddr[1:0], MMIO_BASE};

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + AW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_ptr == AW'(DEPTH - 1)) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign busy_o = (r_state == S_CLEAR);

  // ---------------------------------------------------------------------------
  // Memory array: a single write port shared by the sweep and core stores.
  // The array itself has no reset; only the sweep zeroes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_CLEAR)
      r_mem[r_clr_ptr] <= '0;
    else if (w_wr_en && w_wr_ram_hit)
      r_mem[w_wr_idx] <= bus.ram_wdata;
  end

`ifdef DATA_RAM_MMIO_EN
  // ---------------------------------------------------------------------------
  // MMIO window
  // ---------------------------------------------------------------------------
  logic [31:0] r_cycle, r_gpio, r_tohost;
  logic        r_halt;
  logic        w_wr_mmio_hit, w_rd_mmio_hit;

  assign w_wr_mmio_hit = (bus.ram_waddr[31:4] == MMIO_BASE[31:4]);
  assign w_rd_mmio_hit = (bus.raddr[31:4] == MMIO_BASE[31:4]);

  // The cycle counter counts READY cycles only, so it reads 0 right after the sweep.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_CLEAR) r_cycle <= '0;
    else                           r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio   <= '0;
      r_tohost <= '0;
      r_halt   <= 1'b0;
    end else if (w_wr_en && w_wr_mmio_hit) begin
      case (bus.ram_waddr[3:2])
        2'd1: r_gpio <= bus.ram_wdata;
        2'd2: begin
          r_tohost <= bus.ram_wdata;
          // A zero write updates tohost_o but never clears halt.
          if (bus.ram_wdata != '0) r_halt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gpio_o   = r_gpio;
  assign halt_o   = r_halt;
  assign tohost_o = r_tohost;
`else
  assign gpio_o   = '0;
  assign halt_o   = 1'b0;
  assign tohost_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // Load path. It is combinational and returns 0 during the sweep and for
  // unmapped addresses. MMIO reads have no forwarding path.
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_ready) begin
      if (w_rd_ram_hit) begin
        if (w_bypass) w_rdata = bus.ram_wdata;
        else          w_rdata = r_mem[w_rd_idx];
      end
`ifdef DATA_RAM_MMIO_EN
      else if (w_rd_mmio_hit) begin
        case (bus.raddr[3:2])
          2'd0:    w_rdata = r_cycle;
          2'd1:    w_rdata = r_gpio;
          2'd2:    w_rdata = r_tohost;
          default: w_rdata = '0;
        endcase
      end
`endif
    end
  end

  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder with DEPTH=16.
// A word-level model tracks the memory contents, the remaining clear cycles and
// the MMIO registers. It is compared against the DUT on every negedge.
// Directed steps add literal expectations.
module tb_data_ram_responder;
  localparam int          DEPTH = 16;
  localparam int          TAW   = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy_o, halt_o;
  logic [31:0] gpio_o, tohost_o;

  data_ram_if bus();

  data_ram_responder #(.DEPTH(DEPTH), .AW(TAW), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy_o), .gpio_o(gpio_o), .halt_o(halt_o), .tohost_o(tohost_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model. Reset zeroes the model memory at once: loads read 0 for the whole
  // sweep, and a finished sweep leaves every word 0.
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH];
  int          m_left = DEPTH;
  logic [31:0] m_cnt = '0, m_gpio = '0, m_tohost = '0;
  logic        m_halt = 1'b0;

  function automatic bit ram_hit(input logic [31:0] a);
    return a[31:TAW+2] == '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left <= DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_cnt <= '0; m_gpio <= '0; m_tohost <= '0; m_halt <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_cnt  <= '0;
    end else begin
      m_cnt <= m_cnt + 32'd1;
      if (bus.ram_wreg) begin
        if (ram_hit(bus.ram_waddr)) m_mem[bus.ram_waddr[TAW+1:2]] <= bus.ram_wdata;
`ifdef DATA_RAM_MMIO_EN
        else if (bus.ram_waddr[31:4] == BASE[31:4]) begin
          if (bus.ram_waddr[3:2] == 2'd1) m_gpio <= bus.ram_wdata;
          if (bus.ram_waddr[3:2] == 2'd2) begin
            m_tohost <= bus.ram_wdata;
            if (bus.ram_wdata != 0) m_halt <= 1'b1;
          end
        end
`endif
      end
    end
  end

  function automatic logic [31:0] exp_rd();
    if (m_left != 0) return '0;
    if (ram_hit(bus.raddr)) begin
      if (bus.ram_wreg && ram_hit(bus.ram_waddr) &&
          bus.ram_waddr[TAW+1:2] == bus.raddr[TAW+1:2]) return bus.ram_wdata;
      return m_mem[bus.raddr[TAW+1:2]];
    end
`ifdef DATA_RAM_MMIO_EN
    if (bus.raddr[31:4] == BASE[31:4]) begin
      case (bus.raddr[3:2])
        2'd0: return m_cnt;
        2'd1: return m_gpio;
        2'd2: return m_tohost;
        default: return '0;
      endcase
    end
`endif
    return '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata",  bus.rdata,         exp_rd());
      chk("busy",   {31'd0, busy_o},   {31'd0, m_left != 0});
      chk("gpio",   gpio_o,            m_gpio);
      chk("halt",   {31'd0, halt_o},   {31'd0, m_halt});
      chk("tohost", tohost_o,          m_tohost);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.ram_wreg = 1'b1; bus.ram_waddr = a; bus.ram_wdata = d;
    tick();
    bus.ram_wreg = 1'b0;
  endtask

  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.raddr = a;
    @(negedge clk);
    chk(nm, bus.rdata, exp);
  endtask

  // Counts cycles with busy_o high after rst is released. The count is bounded.
  task automatic wait_clear(input string nm);
    int n = 0;
    do begin tick(); n++; end while (busy_o && n < 100);
    chk(nm, n, 16);
  endtask

  logic [31:0] c0, c1;

  initial begin
    bus.ram_wreg = 1'b0; bus.ram_waddr = '0; bus.ram_wdata = '0; bus.raddr = '0;
    // Reset and clear sweep
    rst = 1'b1;
    tick(); chk_en = 1'b1;
    tick(); tick();
    chk("reset_busy", {31'd0, busy_o}, 32'd1);
    chk("reset_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    wait_clear("clear_len");
    for (int a = 0; a < 64; a += 4) peek("cleared", a, 32'd0);

    // Basic store/load, including ignored low address bits
    tick();
    store(32'h8, 32'hDEAD_BEEF);
    peek("load_8", 32'h8, 32'hDEAD_BEEF);
    peek("load_A", 32'hA, 32'hDEAD_BEEF);

    // Same-cycle forwarding
    tick();
    bus.ram_wreg = 1'b1; bus.ram_waddr = 32'h10; bus.ram_wdata = 32'h1234_5678; bus.raddr = 32'h10;
    @(negedge clk); chk("bypass", bus.rdata, 32'h1234_5678);
    tick(); bus.ram_wreg = 1'b0;
    peek("persist_10", 32'h10, 32'h1234_5678);

    // Unmapped access (just above the 16-word RAM)
    tick();
    store(32'h40, 32'hFFFF_FFFF);
    peek("unmapped_40", 32'h40, 32'd0);
    peek("ram0_intact", 32'h0, 32'd0);
    peek("ram8_intact", 32'h8, 32'hDEAD_BEEF);

    // Reset mid-clear and stores during the sweep
    tick();
    store(32'h4, 32'h55);
    peek("load_4", 32'h4, 32'h55);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (5) tick();                 // clear pointer now at 5
    rst = 1'b1; tick(); rst = 1'b0;
    bus.ram_wreg = 1'b1; bus.ram_waddr = 32'h20; bus.ram_wdata = 32'hAA;
    wait_clear("reclear_len");
    bus.ram_wreg = 1'b0;
    peek("drop_20", 32'h20, 32'd0);
    peek("clear_4", 32'h4, 32'd0);

`ifdef DATA_RAM_MMIO_EN
    tick();
    bus.raddr = BASE; @(negedge clk); c0 = bus.rdata;
    repeat (10) tick();
    @(negedge clk); c1 = bus.rdata;
    chk("cycle_delta", c1 - c0, 32'd10);
    tick();
    store(BASE + 32'h4, 32'hA5);
    chk("gpio_a5", gpio_o, 32'hA5);
    store(BASE + 32'h8, 32'h0);
    chk("halt_zero", {31'd0, halt_o}, 32'd0);
    store(BASE + 32'h8, 32'h1);
    chk("halt_set", {31'd0, halt_o}, 32'd1);
    chk("tohost_1", tohost_o, 32'd1);
    store(BASE + 32'h8, 32'h0);
    repeat (3) tick();
    chk("halt_sticky", {31'd0, halt_o}, 32'd1);
    chk("tohost_0", tohost_o, 32'd0);
    store(BASE, 32'h1234);               // CYCLE is read-only
    rst = 1'b1; tick(); rst = 1'b0;
    chk("halt_rst", {31'd0, halt_o}, 32'd0);
    chk("gpio_rst", gpio_o, 32'd0);
    wait_clear("final_clear");
`else
    tick();
    store(BASE + 32'h4, 32'hA5);
    chk("gpio_off", gpio_o, 32'd0);
    store(BASE + 32'h8, 32'h1);
    chk("halt_off", {31'd0, halt_o}, 32'd0);
    peek("mmio_unmapped", BASE + 32'h4, 32'd0);
    c0 = '0; c1 = '0;
`endif
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
